// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame serializer slice.
package fft_pkg;

    localparam int unsigned DEF_BIT_WIDTH = 32;
    localparam int unsigned DEF_N_SAMPLES = 8;
    localparam int unsigned IDX_W         = $clog2(DEF_N_SAMPLES);

    // One complex sample; real part occupies the upper half when flattened.
    typedef struct packed {
        logic [DEF_BIT_WIDTH-1:0] re;
        logic [DEF_BIT_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } ser_state_t;

    // Reverse the low nbits of idx; bits above nbits come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] idx, input int unsigned nbits);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r[5'(i)] = idx[5'(nbits - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_select.sv
// Combinational N:1 complex-sample mux over a flattened frame buffer.
// Word k of the frame is imag[k]; word N_SAMPLES+k is real[k].
module fft_sample_select #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8
) (
    input  logic [2*BIT_WIDTH*N_SAMPLES-1:0] i_frame,
    input  logic [$clog2(N_SAMPLES)-1:0]     i_sel,
    output logic [2*BIT_WIDTH-1:0]           o_sample
);

    typedef struct packed {
        logic [BIT_WIDTH-1:0] re;
        logic [BIT_WIDTH-1:0] im;
    } sample_t;

    sample_t w_samples [N_SAMPLES];

    for (genvar k = 0; k < N_SAMPLES; k++) begin : g_unpack
        assign w_samples[k] = {i_frame[BIT_WIDTH*(N_SAMPLES+k) +: BIT_WIDTH],
                               i_frame[BIT_WIDTH*k +: BIT_WIDTH]};
    end

    // Pick the addressed sample; index width exactly covers N_SAMPLES entries.
    always_comb begin
        o_sample = w_samples[i_sel];
    end

endmodule

// File: rtl/fft_frame_serializer.sv
// Accepts one flattened complex frame and streams it out one sample per
// handshake, optionally in bit-reversed index order. A new frame can be
// accepted on the last beat of the current one, so back-to-back frames
// stream without a bubble.
module fft_frame_serializer
    import fft_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned DECIMAL_PT  = 16,
    parameter int unsigned N_SAMPLES   = 8,
    parameter int unsigned BIT_REVERSE = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2*BIT_WIDTH*N_SAMPLES-1:0] recv_msg,
    input  logic                             recv_val,
    output logic                             recv_rdy,
    output logic [2*BIT_WIDTH-1:0]           send_msg,
    output logic [$clog2(N_SAMPLES)-1:0]     send_idx,
    output logic                             send_last,
    output logic                             send_val,
    input  logic                             send_rdy
);

    localparam int unsigned CNT_W   = $clog2(N_SAMPLES);
    localparam int unsigned FRAME_W = 2 * BIT_WIDTH * N_SAMPLES;

    if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0) ||
        (DECIMAL_PT > BIT_WIDTH)) begin : g_bad_params
        $error("fft_frame_serializer: N_SAMPLES must be a power of two >= 2 and DECIMAL_PT <= BIT_WIDTH");
    end

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_sel;
    logic [FRAME_W-1:0] r_buf;
    logic             w_load;
    logic             w_last;
    logic             w_recv_hs;
    logic             w_send_hs;

    // Handshake outputs and beat index; recv_rdy forced low while reset is held.
    always_comb begin
        w_last    = (r_state == S_STREAM) && (r_cnt == CNT_W'(N_SAMPLES - 1));
        recv_rdy  = reset && ((r_state == S_IDLE) || (w_last && send_rdy));
        send_val  = (r_state == S_STREAM);
        send_last = w_last;
        w_recv_hs = recv_val && recv_rdy;
        w_send_hs = send_val && send_rdy;
        if (BIT_REVERSE != 0) begin
            w_sel = CNT_W'(bit_rev(32'(r_cnt), CNT_W));
        end else begin
            w_sel = r_cnt;
        end
        send_idx = w_sel;
    end

    // Next state, beat counter and buffer-load decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_recv_hs) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_send_hs) begin
                    if (!w_last) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else if (w_recv_hs) begin
                        w_load    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and frame buffer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_buf <= recv_msg;
            end
        end
    end

    fft_sample_select #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES)
    ) u_sample_select (
        .i_frame  (r_buf),
        .i_sel    (w_sel),
        .o_sample (send_msg)
    );

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed bench: natural order, bit-reversed order, random stalls,
// back-to-back frames, a two-sample variant and reset mid-stream.
module tb_fft_frame_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-sample natural order
    logic [511:0] a_recv_msg;
    logic         a_recv_val, a_recv_rdy, a_send_last, a_send_val, a_send_rdy;
    logic [63:0]  a_send_msg;
    logic [2:0]   a_send_idx;
    // 8-sample bit-reversed
    logic [511:0] b_recv_msg;
    logic         b_recv_val, b_recv_rdy, b_send_last, b_send_val, b_send_rdy;
    logic [63:0]  b_send_msg;
    logic [2:0]   b_send_idx;
    // 2-sample natural order
    logic [127:0] c_recv_msg;
    logic         c_recv_val, c_recv_rdy, c_send_last, c_send_val, c_send_rdy;
    logic [63:0]  c_send_msg;
    logic [0:0]   c_send_idx;

    fft_frame_serializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .BIT_REVERSE(0)) u_dut_a (
        .clk(clk), .reset(rst_n), .recv_msg(a_recv_msg), .recv_val(a_recv_val), .recv_rdy(a_recv_rdy),
        .send_msg(a_send_msg), .send_idx(a_send_idx), .send_last(a_send_last),
        .send_val(a_send_val), .send_rdy(a_send_rdy));

    fft_frame_serializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .BIT_REVERSE(1)) u_dut_b (
        .clk(clk), .reset(rst_n), .recv_msg(b_recv_msg), .recv_val(b_recv_val), .recv_rdy(b_recv_rdy),
        .send_msg(b_send_msg), .send_idx(b_send_idx), .send_last(b_send_last),
        .send_val(b_send_val), .send_rdy(b_send_rdy));

    fft_frame_serializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(2), .BIT_REVERSE(0)) u_dut_c (
        .clk(clk), .reset(rst_n), .recv_msg(c_recv_msg), .recv_val(c_recv_val), .recv_rdy(c_recv_rdy),
        .send_msg(c_send_msg), .send_idx(c_send_idx), .send_last(c_send_last),
        .send_val(c_send_val), .send_rdy(c_send_rdy));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Frame f sample j: real = (j+8f)<<16, imag = -real.
    function automatic logic [63:0] smp(input int f, input int j);
        logic [31:0] re;
        re = 32'((j + 8 * f) << 16);
        return {re, -re};
    endfunction

    function automatic logic [511:0] frame8(input int f);
        logic [511:0] fr;
        logic [63:0]  s;
        fr = '0;
        for (int k = 0; k < 8; k++) begin
            s = smp(f, k);
            fr[32*(8+k) +: 32] = s[63:32];
            fr[32*k +: 32]     = s[31:0];
        end
        return fr;
    endfunction

    function automatic logic [127:0] frame2(input int f);
        logic [127:0] fr;
        logic [63:0]  s;
        fr = '0;
        for (int k = 0; k < 2; k++) begin
            s = smp(f, k);
            fr[32*(2+k) +: 32] = s[63:32];
            fr[32*k +: 32]     = s[31:0];
        end
        return fr;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rev8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int beat;
        int cyc;
        int f;
        int j;

        rst_n = 1'b0;
        a_recv_msg = '0; a_recv_val = 1'b0; a_send_rdy = 1'b0;
        b_recv_msg = '0; b_recv_val = 1'b0; b_send_rdy = 1'b0;
        c_recv_msg = '0; c_recv_val = 1'b0; c_send_rdy = 1'b0;

        // Reset state
        #2;
        check("rst_send_val", 64'(a_send_val), 64'd0);
        check("rst_recv_rdy", 64'(a_recv_rdy), 64'd0);
        check("rst_send_last", 64'(a_send_last), 64'd0);
        check("rst_send_idx", 64'(a_send_idx), 64'd0);
        check("rst_send_msg", a_send_msg, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_recv_rdy", 64'(a_recv_rdy), 64'd1);
        check("rel_send_idx", 64'(a_send_idx), 64'd0);

        // Natural and bit-reversed order, one frame each, no stalls
        @(negedge clk);
        a_recv_msg = frame8(0); a_recv_val = 1'b1; a_send_rdy = 1'b1;
        b_recv_msg = frame8(0); b_recv_val = 1'b1; b_send_rdy = 1'b1;
        @(negedge clk);
        a_recv_val = 1'b0;
        b_recv_val = 1'b0;
        for (int b = 0; b < 8; b++) begin
            check($sformatf("nat_val_b%0d", b), 64'(a_send_val), 64'd1);
            check($sformatf("nat_idx_b%0d", b), 64'(a_send_idx), 64'(b));
            check($sformatf("nat_msg_b%0d", b), a_send_msg, smp(0, b));
            check($sformatf("nat_last_b%0d", b), 64'(a_send_last), 64'(b == 7));
            check($sformatf("rev_idx_b%0d", b), 64'(b_send_idx), 64'(rev8[b]));
            check($sformatf("rev_msg_b%0d", b), b_send_msg, smp(0, rev8[b]));
            check($sformatf("rev_last_b%0d", b), 64'(b_send_last), 64'(b == 7));
            if (b == 3) begin
                check("nat_msg_beat3_const", a_send_msg, 64'h00030000_FFFD0000);
            end
            @(negedge clk);
        end
        check("nat_idle_val", 64'(a_send_val), 64'd0);
        check("nat_idle_rdy", 64'(a_recv_rdy), 64'd1);
        check("rev_idle_val", 64'(b_send_val), 64'd0);

        // Random back-pressure: outputs must hold while stalled
        a_recv_msg = frame8(1); a_recv_val = 1'b1; a_send_rdy = 1'b0;
        @(negedge clk);
        a_recv_val = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 200) begin
            check($sformatf("stall_val_c%0d", cyc), 64'(a_send_val), 64'd1);
            check($sformatf("stall_idx_c%0d", cyc), 64'(a_send_idx), 64'(beat));
            check($sformatf("stall_msg_c%0d", cyc), a_send_msg, smp(1, beat));
            check($sformatf("stall_last_c%0d", cyc), 64'(a_send_last), 64'(beat == 7));
            a_send_rdy = 1'($urandom_range(0, 1));
            if (a_send_rdy) beat++;
            cyc++;
            @(negedge clk);
        end
        check("stall_beats_done", 64'(beat), 64'd8);
        check("stall_idle_val", 64'(a_send_val), 64'd0);

        // Three back-to-back frames with recv_val held high
        a_recv_msg = frame8(2); a_recv_val = 1'b1; a_send_rdy = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 24; g++) begin
            f = 2 + g / 8;
            j = g % 8;
            check($sformatf("b2b_val_g%0d", g), 64'(a_send_val), 64'd1);
            check($sformatf("b2b_idx_g%0d", g), 64'(a_send_idx), 64'(j));
            check($sformatf("b2b_msg_g%0d", g), a_send_msg, smp(f, j));
            check($sformatf("b2b_rdy_g%0d", g), 64'(a_recv_rdy), 64'(j == 7));
            check($sformatf("b2b_last_g%0d", g), 64'(a_send_last), 64'(j == 7));
            if (j == 0) begin
                if (g / 8 < 2) a_recv_msg = frame8(f + 1);
                else           a_recv_val = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_idle_val", 64'(a_send_val), 64'd0);

        // Two-sample variant, two back-to-back frames
        c_recv_msg = frame2(0); c_recv_val = 1'b1; c_send_rdy = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            f = g / 2;
            j = g % 2;
            check($sformatf("n2_val_g%0d", g), 64'(c_send_val), 64'd1);
            check($sformatf("n2_idx_g%0d", g), 64'(c_send_idx), 64'(j));
            check($sformatf("n2_msg_g%0d", g), c_send_msg, smp(f, j));
            check($sformatf("n2_last_g%0d", g), 64'(c_send_last), 64'(j == 1));
            check($sformatf("n2_rdy_g%0d", g), 64'(c_recv_rdy), 64'(j == 1));
            if (j == 0) begin
                if (f == 0) c_recv_msg = frame2(1);
                else        c_recv_val = 1'b0;
            end
            @(negedge clk);
        end
        check("n2_idle_val", 64'(c_send_val), 64'd0);

        // Reset asserted mid-frame
        a_recv_msg = frame8(3); a_recv_val = 1'b1; a_send_rdy = 1'b1;
        @(negedge clk);
        a_recv_val = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_pre_idx", 64'(a_send_idx), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_val", 64'(a_send_val), 64'd0);
        check("mid_rst_rdy", 64'(a_recv_rdy), 64'd0);
        check("mid_rst_last", 64'(a_send_last), 64'd0);
        check("mid_rst_idx", 64'(a_send_idx), 64'd0);
        check("mid_rst_msg", a_send_msg, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_rdy", 64'(a_recv_rdy), 64'd1);
        check("mid_rel_idx", 64'(a_send_idx), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_no_partial_%0d", k), 64'(a_send_val), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
